if_stage_fetch: RTL and testbench
=================================

// Module: if_stage_fetch
// PURPOSE
//  Instruction-fetch stage, directly upstream of the ID-stage control unit. Owns the PC, fetches
//  32-bit ARM words over a req/ack handshake to instruction memory, and drives the IF/ID register.
//  Honours the hazard-unit stall, and redirects/flushes on a taken branch resolved downstream.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  NOP_INSTR  32'hE1A0_0000  bubble word (MOV r0,r0) placed in IF/ID on flush/bubble
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  imem_req       out  1   fetch request to instruction memory
//  imem_addr      out  32  fetch address (= PC, word aligned)
//  imem_ack       in   1   memory returns imem_rdata this cycle
//  imem_rdata     in   32  fetched instruction word
//  stall          in   1   hazard unit: hold IF/ID contents, do not advance
//  branch_taken   in   1   taken branch resolved: redirect fetch, flush IF/ID
//  branch_target  in   32  redirect address; bits [1:0] ignored (forced 00)
//  IF_ID_instr    out  32  instruction to ID stage
//  IF_ID_pc4      out  32  address of IF_ID_instr + 4
//  IF_ID_valid    out  1   IF_ID_instr is a real instruction
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, state=IDLE, imem_req=0, IF_ID_instr=NOP_INSTR,
//   IF_ID_pc4=0, IF_ID_valid=0, skid buffer cleared. All outputs registered.
//  States: IDLE, REQ, HOLD, DISCARD.
//  IDLE: one cycle after rst_n release -> REQ.
//  REQ: imem_req=1, imem_addr=pc; addr stays stable while req=1 and no ack.
//   ack & !stall: IF/ID <= {rdata, pc+4, valid=1}; pc <= pc+4; stay REQ (1 instr/cycle max).
//   ack & stall: rdata, pc+4 -> skid buffer; IF/ID held; req drops; -> HOLD.
//   !ack & !stall: IF/ID <= {NOP_INSTR, pc4 held, valid=0} (bubble). !ack & stall: IF/ID held.
//  HOLD: imem_req=0. stall=0: IF/ID <= skid buffer, valid=1; pc <= pc+4; -> REQ next cycle.
//  DISCARD: imem_req=1 at old addr until ack; returned word dropped; then pc already = target,
//   -> REQ. IF/ID stays NOP/valid=0 during DISCARD.
//  Branch (priority over stall and ack, any state):
//   IF/ID <= NOP_INSTR, valid=0; skid buffer discarded; pc <= {branch_target[31:2],2'b00}.
//   From REQ with no ack that cycle -> DISCARD (handshake never abandoned mid-request).
//   From REQ with ack, HOLD or IDLE -> REQ; target fetched next cycle.
//   Branch during DISCARD: pc updated to newest target, remain DISCARD.
//  Arithmetic: pc+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0); no overflow flag.
//  Fetch latency: instruction appears in IF/ID the cycle after its ack (stall=0).
//  Reset mid-request: outstanding request abandoned; memory must tolerate req dropping on reset.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds out ports perf_fetch_cnt[31:0] (+1 per instr written to IF/ID
//   with valid=1) and perf_bubble_cnt[31:0] (+1 per cycle IF/ID loads NOP while !stall);
//   both reset to 0, wrap at 2^32, not affected by stall-hold cycles.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset RESET_PC=0x100, ack every cycle, rdata=addr -> addrs 0x100,0x104,0x108; IF_ID_pc4 0x104.. valid=1.
//  2 Ack at 0x200 with stall=1 for 3 cycles -> req low, IF/ID held; stall drop -> IF_ID_instr=word@0x200, next req 0x204.
//  3 branch_taken target 0x403 while ack same cycle -> IF/ID NOP valid=0, next imem_addr=0x400.
//  4 branch while req pending no ack at 0x300, ack 2 cycles later -> addr held 0x300, data dropped, then 0x3xx target.
//  5 pc=0xFFFF_FFFC ack -> IF_ID_pc4=0, next imem_addr=0; branch+stall same cycle -> flush wins.
//  6 IF_PERF_CNT_EN: 10 fetches, 3 no-ack cycles -> perf_fetch_cnt=10, perf_bubble_cnt=3.

Source files
------------

// File: rtl/if_stage_fetch_if.sv
// Bundles the fetch stage's instruction-memory handshake, hazard/branch controls and IF/ID outputs.
// The master modport is the fetch stage; the slave modport is the memory/pipeline environment.
interface if_stage_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_pc4;
  logic        IF_ID_valid;

  modport master (
    output imem_req, imem_addr, IF_ID_instr, IF_ID_pc4, IF_ID_valid,
    input  imem_ack, imem_rdata, stall, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, IF_ID_instr, IF_ID_pc4, IF_ID_valid,
    output imem_ack, imem_rdata, stall, branch_taken, branch_target
  );
endinterface

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over req/ack, fills IF/ID, handles stall and branch flush.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_stage_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  if_stage_fetch_if.master        bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]             perf_fetch_cnt,
  output logic [31:0]             perf_bubble_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic [31:0] target;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc4;

  assign pc_inc = pc + 32'd4;
  assign target = bus.branch_target & 32'hFFFF_FFFC;

  // imem_addr is kept apart from pc: in DISCARD the old request stays on the bus while pc already holds the target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      bus.imem_req    <= 1'b0;
      bus.imem_addr   <= RESET_PC;
      bus.IF_ID_instr <= NOP_INSTR;
      bus.IF_ID_pc4   <= 32'd0;
      bus.IF_ID_valid <= 1'b0;
      skid_instr      <= 32'd0;
      skid_pc4        <= 32'd0;
    end else if (bus.branch_taken) begin
      bus.IF_ID_instr <= NOP_INSTR;
      bus.IF_ID_valid <= 1'b0;
      pc              <= target;
      if ((state == REQ || state == DISCARD) && !bus.imem_ack) begin
        state <= DISCARD;
      end else begin
        state         <= REQ;
        bus.imem_req  <= 1'b1;
        bus.imem_addr <= target;
      end
    end else begin
      case (state)
        IDLE: begin
          state         <= REQ;
          bus.imem_req  <= 1'b1;
          bus.imem_addr <= pc;
        end
        REQ: begin
          if (bus.imem_ack && !bus.stall) begin
            bus.IF_ID_instr <= bus.imem_rdata;
            bus.IF_ID_pc4   <= pc_inc;
            bus.IF_ID_valid <= 1'b1;
            pc              <= pc_inc;
            bus.imem_addr   <= pc_inc;
          end else if (bus.imem_ack) begin
            skid_instr   <= bus.imem_rdata;
            skid_pc4     <= pc_inc;
            bus.imem_req <= 1'b0;
            state        <= HOLD;
          end else if (!bus.stall) begin
            bus.IF_ID_instr <= NOP_INSTR;
            bus.IF_ID_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!bus.stall) begin
            bus.IF_ID_instr <= skid_instr;
            bus.IF_ID_pc4   <= skid_pc4;
            bus.IF_ID_valid <= 1'b1;
            pc              <= pc_inc;
            bus.imem_addr   <= pc_inc;
            bus.imem_req    <= 1'b1;
            state           <= REQ;
          end
        end
        DISCARD: begin
          bus.IF_ID_instr <= NOP_INSTR;
          bus.IF_ID_valid <= 1'b0;
          if (bus.imem_ack) begin
            state         <= REQ;
            bus.imem_addr <= pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic fetch_evt;
  logic bubble_evt;

  assign fetch_evt  = !bus.branch_taken && !bus.stall &&
                      ((state == REQ && bus.imem_ack) || state == HOLD);
  assign bubble_evt = !bus.stall &&
                      (bus.branch_taken || state == DISCARD || (state == REQ && !bus.imem_ack));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt  <= 32'd0;
      perf_bubble_cnt <= 32'd0;
    end else begin
      if (fetch_evt)  perf_fetch_cnt  <= perf_fetch_cnt + 32'd1;
      if (bubble_evt) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage_fetch.sv
// Directed bench for if_stage_fetch: reset, streaming fetch, stall/skid, branch flush, discard, wrap.
module tb_if_stage_fetch;
  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  if_stage_fetch_if bus ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
  if_stage_fetch #(.RESET_PC(32'h0000_0100), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
  );
`else
  if_stage_fetch #(.RESET_PC(32'h0000_0100), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic stl,
                       input logic br, input logic [31:0] tgt);
    bus.imem_ack      = ack;
    bus.imem_rdata    = rdata;
    bus.stall         = stl;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    #12;
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_instr", bus.IF_ID_instr, NOP);
    chk("rst_pc4", bus.IF_ID_pc4, 32'd0);
    chk("rst_valid", {31'd0, bus.IF_ID_valid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // streaming fetch from RESET_PC with rdata = address
    cyc();
    chk("t1_req", {31'd0, bus.imem_req}, 32'd1);
    chk("t1_addr0", bus.imem_addr, 32'h100);
    drive(1'b1, 32'h100, 1'b0, 1'b0, 32'd0);
    cyc();
    chk("t1_instr0", bus.IF_ID_instr, 32'h100);
    chk("t1_pc4_0", bus.IF_ID_pc4, 32'h104);
    chk("t1_valid0", {31'd0, bus.IF_ID_valid}, 32'd1);
    chk("t1_addr1", bus.imem_addr, 32'h104);
    drive(1'b1, 32'h104, 1'b0, 1'b0, 32'd0);
    cyc();
    chk("t1_instr1", bus.IF_ID_instr, 32'h104);
    chk("t1_pc4_1", bus.IF_ID_pc4, 32'h108);
    chk("t1_addr2", bus.imem_addr, 32'h108);

    // branch with ack to 0x200, then ack under stall
    drive(1'b1, 32'h108, 1'b0, 1'b1, 32'h200);
    cyc();
    chk("t2_br_valid", {31'd0, bus.IF_ID_valid}, 32'd0);
    chk("t2_br_addr", bus.imem_addr, 32'h200);
    drive(1'b1, 32'hA200, 1'b1, 1'b0, 32'd0);
    cyc();
    chk("t2_hold_req", {31'd0, bus.imem_req}, 32'd0);
    chk("t2_hold_instr", bus.IF_ID_instr, NOP);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      cyc();
      chk("t2_hold_req_n", {31'd0, bus.imem_req}, 32'd0);
      chk("t2_hold_valid_n", {31'd0, bus.IF_ID_valid}, 32'd0);
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    cyc();
    chk("t2_rel_instr", bus.IF_ID_instr, 32'hA200);
    chk("t2_rel_pc4", bus.IF_ID_pc4, 32'h204);
    chk("t2_rel_valid", {31'd0, bus.IF_ID_valid}, 32'd1);
    chk("t2_rel_req", {31'd0, bus.imem_req}, 32'd1);
    chk("t2_rel_addr", bus.imem_addr, 32'h204);

    // branch to unaligned 0x403 coinciding with an ack
    drive(1'b1, 32'hDEAD, 1'b0, 1'b1, 32'h403);
    cyc();
    chk("t3_instr", bus.IF_ID_instr, NOP);
    chk("t3_valid", {31'd0, bus.IF_ID_valid}, 32'd0);
    chk("t3_pc4_held", bus.IF_ID_pc4, 32'h204);
    chk("t3_addr", bus.imem_addr, 32'h400);
    drive(1'b1, 32'h400, 1'b0, 1'b0, 32'd0);
    cyc();
    chk("t3_instr2", bus.IF_ID_instr, 32'h400);
    chk("t3_pc4_2", bus.IF_ID_pc4, 32'h404);

    // pending request at 0x300, branch without ack -> discard
    drive(1'b1, 32'h404, 1'b0, 1'b1, 32'h300);
    cyc();
    chk("t4_addr", bus.imem_addr, 32'h300);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    cyc();
    chk("t4_bubble_valid", {31'd0, bus.IF_ID_valid}, 32'd0);
    chk("t4_bubble_pc4", bus.IF_ID_pc4, 32'h404);
    drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h3A0);
    cyc();
    chk("t4_disc_addr", bus.imem_addr, 32'h300);
    chk("t4_disc_req", {31'd0, bus.imem_req}, 32'd1);
    drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h3C0);
    cyc();
    chk("t4_disc_addr2", bus.imem_addr, 32'h300);
    drive(1'b1, 32'hBAD0, 1'b0, 1'b0, 32'd0);
    cyc();
    chk("t4_drop_instr", bus.IF_ID_instr, NOP);
    chk("t4_drop_valid", {31'd0, bus.IF_ID_valid}, 32'd0);
    chk("t4_tgt_addr", bus.imem_addr, 32'h3C0);
    drive(1'b1, 32'h3C0, 1'b0, 1'b0, 32'd0);
    cyc();
    chk("t4_tgt_instr", bus.IF_ID_instr, 32'h3C0);
    chk("t4_tgt_pc4", bus.IF_ID_pc4, 32'h3C4);

    // wrap at top of address space, then branch+stall
    drive(1'b1, 32'h3C4, 1'b0, 1'b1, 32'hFFFF_FFFC);
    cyc();
    chk("t5_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    drive(1'b1, 32'h1234, 1'b0, 1'b0, 32'd0);
    cyc();
    chk("t5_wrap_pc4", bus.IF_ID_pc4, 32'd0);
    chk("t5_wrap_instr", bus.IF_ID_instr, 32'h1234);
    chk("t5_wrap_addr", bus.imem_addr, 32'd0);
    drive(1'b1, 32'h5555, 1'b1, 1'b1, 32'h500);
    cyc();
    chk("t5_flush_valid", {31'd0, bus.IF_ID_valid}, 32'd0);
    chk("t5_flush_instr", bus.IF_ID_instr, NOP);
    chk("t5_flush_req", {31'd0, bus.imem_req}, 32'd1);
    chk("t5_flush_addr", bus.imem_addr, 32'h500);

    // asynchronous reset while a request is outstanding
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("arst_valid", {31'd0, bus.IF_ID_valid}, 32'd0);
    chk("arst_addr", bus.imem_addr, 32'h100);

`ifdef IF_PERF_CNT_EN
    @(negedge clk) rst_n = 1'b1;
    cyc();
    for (int i = 0; i < 13; i++) begin
      if (i == 3 || i == 7 || i == 11) drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      else drive(1'b1, 32'h1000 + i, 1'b0, 1'b0, 32'd0);
      cyc();
    end
    chk("t6_fetch_cnt", perf_fetch_cnt, 32'd10);
    chk("t6_bubble_cnt", perf_bubble_cnt, 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
